key_event_decoder: RTL and testbench

- Consumes the debounced key interface: a one-cycle press pulse plus the synchronized active-low key level.
- Classifies each gesture as SHORT, DOUBLE, LONG or (optionally) REPEAT.
- Presents each classification as an event code on a valid/ready output toward the application logic (LED/mode control).
- One instance per key.

---
 rtl/key_evt_pkg.sv | 17 +
 rtl/evt_hold_reg.sv | 39 +++
 rtl/key_event_decoder.sv | 112 +++++++++++
 tb/tb_key_event_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared types for the key gesture decoder: FSM states and event codes.
package key_evt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD1 = 3'd1,
        WAIT2 = 3'd2,
        HELD2 = 3'd3,
        LONGH = 3'd4
    } state_t;

    localparam logic [1:0] EVT_SHORT  = 2'd0;
    localparam logic [1:0] EVT_DOUBLE = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

endpackage

// File: rtl/evt_hold_reg.sv
// Single-entry event holding register with valid/ready handshake and a
// sticky overflow flag raised when an unaccepted event is overwritten.
module evt_hold_reg (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_emit,
    input  logic [1:0] i_code,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [1:0] o_code,
    output logic       o_ovf
);

    logic       r_valid;
    logic [1:0] r_code;
    logic       r_ovf;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_code  <= 2'd0;
            r_ovf   <= 1'b0;
        end else if (i_emit) begin
            // A new event always lands; it only counts as lost data if the
            // held one was not being taken this same cycle.
            r_valid <= 1'b1;
            r_code  <= i_code;
            if (r_valid && !i_ready)
                r_ovf <= 1'b1;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_code  = r_code;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced key gestures into SHORT/DOUBLE/LONG(/REPEAT) events.
// REPEAT generation while held after LONG is enabled by KEY_REPEAT_EN.
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int unsigned CNT_W        = 22,
    parameter int unsigned LONG_TICKS   = 32'h2FFFFF,
    parameter int unsigned DBL_TICKS    = 32'h17FFFF,
    parameter int unsigned REPEAT_TICKS = 32'h0FFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_press,
    input  logic       key_n,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_ovf,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_TICKS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             w_emit;
    logic [1:0]       w_code;
    logic             w_cnt_clr;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_TICKS - 1);
`else
    logic w_unused_rpt;
    assign w_unused_rpt = ^REPEAT_TICKS;
`endif

    always_comb begin
        w_next    = r_state;
        w_emit    = 1'b0;
        w_code    = EVT_SHORT;
        w_cnt_clr = 1'b0;
        case (r_state)
            IDLE: if (key_press) w_next = HELD1;
            HELD1: begin
                if (key_n) begin
                    w_next = WAIT2;
                end else if (r_cnt == LONG_LAST) begin
                    w_emit = 1'b1;
                    w_code = EVT_LONG;
                    w_next = LONGH;
                end
            end
            WAIT2: begin
                if (key_press) begin
                    w_emit = 1'b1;
                    w_code = EVT_DOUBLE;
                    w_next = HELD2;
                end else if (r_cnt == DBL_LAST) begin
                    w_emit = 1'b1;
                    w_code = EVT_SHORT;
                    w_next = IDLE;
                end
            end
            HELD2: if (key_n) w_next = IDLE;
            LONGH: begin
                if (key_n) begin
                    w_next = IDLE;
`ifdef KEY_REPEAT_EN
                end else if (r_cnt == RPT_LAST) begin
                    w_emit    = 1'b1;
                    w_code    = EVT_REPEAT;
                    w_cnt_clr = 1'b1;
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            // Saturate rather than wrap so a stuck key can't re-fire a threshold.
            if (w_next != r_state || w_cnt_clr)
                r_cnt <= '0;
            else if (r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + 1'b1;
        end
    end

    evt_hold_reg u_hold (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_emit  (w_emit),
        .i_code  (w_code),
        .i_ready (evt_ready),
        .o_valid (evt_valid),
        .o_code  (evt_code),
        .o_ovf   (evt_ovf)
    );

    assign busy = r_busy;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder with small thresholds
// (LONG=20, DBL=10, REPEAT=5, CNT_W=8); follows KEY_REPEAT_EN if defined.
module tb_key_event_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_press;
    logic       key_n;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ovf;
    logic       busy;

    key_event_decoder #(
        .CNT_W        (8),
        .LONG_TICKS   (20),
        .DBL_TICKS    (10),
        .REPEAT_TICKS (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_press (key_press),
        .key_n     (key_n),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .evt_ovf   (evt_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] code;
        int         at;    // cycle the event must appear; -1 = don't care
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] c, input int at);
        exp_t e;
        e.code = c;
        e.at   = at;
        q.push_back(e);
    endtask

    // Monitor: every accepted event must match the head of the scoreboard.
    exp_t m_e;
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_event: got code %0d at cyc %0d, want no event", evt_code, cyc);
            end else begin
                m_e = q.pop_front();
                chk("evt_code", int'(evt_code), int'(m_e.code));
                if (m_e.at >= 0) chk("evt_time", cyc, m_e.at);
            end
        end
    end

    task automatic press_start();
        key_press = 1'b1;
        key_n     = 1'b0;
        tick(1);
        key_press = 1'b0;
    endtask

    initial begin
        int c;
        int p;
        rst_n     = 1'b0;
        key_press = 1'b0;
        key_n     = 1'b1;
        evt_ready = 1'b1;
        tick(2);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_code",  int'(evt_code),  0);
        chk("rst_ovf",   int'(evt_ovf),   0);
        chk("rst_busy",  int'(busy),      0);
        rst_n = 1'b1;
        tick(2);

        // Short press: SHORT 11 cycles after the release is driven
        press_start();
        chk("busy_held", int'(busy), 1);
        tick(4);
        key_n = 1'b1;
        c = cyc;
        push(2'd0, c + 11);
        tick(11);
        chk("busy_after_short", int'(busy), 0);
        tick(3);

        // Double press, second press held 30 cycles: no LONG
        press_start();
        tick(2);
        key_n = 1'b1;
        tick(4);
        key_press = 1'b1;
        key_n     = 1'b0;
        p = cyc;
        push(2'd1, p + 1);
        tick(1);
        key_press = 1'b0;
        tick(30);
        key_n = 1'b1;
        tick(15);

        // Long press
        p = cyc;
        push(2'd2, p + 21);
`ifdef KEY_REPEAT_EN
        push(2'd3, p + 26);
        push(2'd3, p + 31);
        push(2'd3, p + 36);
        push(2'd3, p + 41);
`endif
        press_start();
        tick(40);
        key_n = 1'b1;
        tick(15);

        // Release on the cnt==19 cycle: release wins, SHORT follows
        press_start();
        tick(19);
        key_n = 1'b1;
        c = cyc;
        push(2'd0, c + 11);
        tick(30);

        // Second press on the WAIT2 cnt==9 cycle: DOUBLE wins
        press_start();
        tick(2);
        key_n = 1'b1;
        c = cyc;
        tick(10);
        key_press = 1'b1;
        key_n     = 1'b0;
        push(2'd1, c + 11);
        tick(1);
        key_press = 1'b0;
        tick(2);
        key_n = 1'b1;
        tick(15);

        // Overwrite with consumer stalled: LONG then DOUBLE
        evt_ready = 1'b0;
        press_start();
        tick(20);
        chk("hs_long_valid", int'(evt_valid), 1);
        chk("hs_long_code",  int'(evt_code),  2);
        chk("hs_long_ovf",   int'(evt_ovf),   0);
        key_n = 1'b1;
        tick(2);
        press_start();
        tick(1);
        key_n = 1'b1;
        tick(3);
        key_press = 1'b1;
        key_n     = 1'b0;
        tick(1);
        key_press = 1'b0;
        chk("hs_dbl_valid", int'(evt_valid), 1);
        chk("hs_dbl_code",  int'(evt_code),  1);
        chk("hs_dbl_ovf",   int'(evt_ovf),   1);
        push(2'd1, -1);
        tick(1);
        key_n = 1'b1;
        tick(3);
        chk("hs_hold_valid", int'(evt_valid), 1);
        evt_ready = 1'b1;
        tick(1);
        chk("hs_acc_valid", int'(evt_valid), 0);
        chk("hs_acc_ovf",   int'(evt_ovf),   1);
        tick(2);

        // Reset during HELD1
        press_start();
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("rh_valid", int'(evt_valid), 0);
        chk("rh_code",  int'(evt_code),  0);
        chk("rh_ovf",   int'(evt_ovf),   0);
        chk("rh_busy",  int'(busy),      0);
        tick(5);
        key_n = 1'b1;
        tick(15);

        // Reset during WAIT2: no SHORT afterwards
        press_start();
        tick(2);
        key_n = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("rw_busy",  int'(busy),      0);
        chk("rw_valid", int'(evt_valid), 0);
        tick(15);

        // Fresh gesture after reset
        press_start();
        tick(2);
        key_n = 1'b1;
        c = cyc;
        push(2'd0, c + 11);
        tick(14);

        chk("pending_events", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
